// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Gshare conditional-branch predictor. The fetch PC is hashed with a global
//   history register (GHR) to index a table of 2-bit saturating counters. Each
//   predicted branch is held in a small in-flight FIFO until it resolves, in
//   program order. When a branch resolves, the PHT is trained. On a
//   mispredict, the history is repaired and the wrong-path entries are
//   flushed.
//
// Handshake semantics:
//   lookup_fire  = lookup_valid & lookup_enable. An entry is pushed only on
//                  lookup_fire. lookup_valid without lookup_enable is a
//                  stalled fetch and has no effect.
//   resolve_fire = resolve_valid & queue not empty. It always refers to the
//                  oldest entry. resolve_valid on an empty queue is ignored.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   pc                    fetch PC being looked up
//   lookup_valid/enable   conditional branch present / fetch not stalled
//   prediction            combinational taken prediction for pc
//   resolve_valid/taken   oldest branch resolved / its actual direction
//   mispredict            combinational, resolved direction != stored guess
//   queue_full            FIFO holds QDEPTH entries
//   overflow              sticky: push attempted while full without a pop
//   resolved_count        number of resolved branches (wraps)
//   mispredict_count      number of mispredictions (wraps)
//   dbg_ghr               current global history register
//   dbg_occupancy         current FIFO occupancy
//
// GHR_BITS must be >= 2 and <= PHT_BITS.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int PHT_BITS = 8,
    parameter int GHR_BITS = 8,
    parameter int QDEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 pc,
    input  logic                        lookup_valid,
    input  logic                        lookup_enable,
    output logic                        prediction,
    input  logic                        resolve_valid,
    input  logic                        resolve_taken,
    output logic                        mispredict,
    output logic                        queue_full,
    output logic                        overflow,
    output logic [31:0]                 resolved_count,
    output logic [31:0]                 mispredict_count,
    output logic [GHR_BITS-1:0]         dbg_ghr,
    output logic [$clog2(QDEPTH+1)-1:0] dbg_occupancy
);

    localparam int PHT_N = 1 << PHT_BITS;
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [1:0]          pht_q [PHT_N];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;

    // FIFO storage. The contents need no reset because occupancy gates them.
    logic [PHT_BITS-1:0] q_idx_q  [QDEPTH];
    logic                q_pred_q [QDEPTH];
    logic [GHR_BITS-1:0] q_ghr_q  [QDEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      resolved_q, resolved_d, misp_cnt_q, misp_cnt_d;

    logic [PHT_BITS-1:0] ghr_ext, lookup_idx, head_idx;
    logic                head_pred;
    logic [GHR_BITS-1:0] head_ghr;
    logic                q_empty, q_full, lookup_fire, resolve_fire, push;
    logic [1:0]          pht_upd;
    logic                unused_pc;

    assign unused_pc = ^{pc[31:PHT_BITS+1], pc[0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // The history is XORed into the low bits of the PC-derived index.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_BITS-1:0] = ghr_q;
    end

    assign lookup_idx   = pc[PHT_BITS:1] ^ ghr_ext;
    assign prediction   = pht_q[lookup_idx][1];

    assign head_idx     = q_idx_q[rd_ptr_q];
    assign head_pred    = q_pred_q[rd_ptr_q];
    assign head_ghr     = q_ghr_q[rd_ptr_q];

    assign q_empty      = (count_q == '0);
    assign q_full       = (count_q == CNT_W'(QDEPTH));
    assign lookup_fire  = lookup_valid & lookup_enable;
    assign resolve_fire = resolve_valid & ~q_empty;
    assign mispredict   = resolve_fire & (resolve_taken != head_pred);

    // A lookup on the wrong path (same cycle as a mispredict) is dropped.
    // A full queue still accepts a push when the head pops in the same cycle.
    assign push = lookup_fire & ~mispredict & (~q_full | resolve_fire);

    always_comb begin
        pht_upd = pht_q[head_idx];
        if (resolve_taken) begin
            if (pht_upd != 2'b11) pht_upd = pht_upd + 2'b01;
        end else begin
            if (pht_upd != 2'b00) pht_upd = pht_upd - 2'b01;
        end
    end

    always_comb begin
        ghr_d      = ghr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        resolved_d = resolved_q;
        misp_cnt_d = misp_cnt_q;
        overflow_d = overflow_q | (lookup_fire & q_full & ~resolve_fire);

        if (resolve_fire) begin
            resolved_d = resolved_q + 32'd1;
        end

        if (mispredict) begin
            // Rebuild the history the branch should have produced and flush
            // every younger (wrong-path) entry.
            misp_cnt_d = misp_cnt_q + 32'd1;
            ghr_d      = {head_ghr[GHR_BITS-2:0], resolve_taken};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (resolve_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                ghr_d    = {ghr_q[GHR_BITS-2:0], prediction};
            end
            if (push && !resolve_fire)      count_d = count_q + 1'b1;
            else if (!push && resolve_fire) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
        end else if (resolve_fire) begin
            pht_q[head_idx] <= pht_upd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            resolved_q <= '0;
            misp_cnt_q <= '0;
        end else begin
            ghr_q      <= ghr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            resolved_q <= resolved_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end

    // The entry records the history before this branch shifts it in.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx_q[wr_ptr_q]  <= lookup_idx;
            q_pred_q[wr_ptr_q] <= prediction;
            q_ghr_q[wr_ptr_q]  <= ghr_q;
        end
    end

    assign queue_full       = q_full;
    assign overflow         = overflow_q;
    assign resolved_count   = resolved_q;
    assign mispredict_count = misp_cnt_q;
    assign dbg_ghr          = ghr_q;
    assign dbg_occupancy    = count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed vector table, hand-written corner-case sequences and a randomized
//   run against a queue-based reference model of the gshare predictor.
//   Inputs are driven 1 time unit after the rising edge. Outputs are sampled
//   on the falling edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int QD = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic        lookup_valid, lookup_enable, resolve_valid, resolve_taken;
    logic        prediction, mispredict, queue_full, overflow;
    logic [31:0] resolved_count, mispredict_count;
    logic [7:0]  dbg_ghr;
    logic [2:0]  dbg_occupancy;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc               (pc),
        .lookup_valid     (lookup_valid),
        .lookup_enable    (lookup_enable),
        .prediction       (prediction),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .mispredict       (mispredict),
        .queue_full       (queue_full),
        .overflow         (overflow),
        .resolved_count   (resolved_count),
        .mispredict_count (mispredict_count),
        .dbg_ghr          (dbg_ghr),
        .dbg_occupancy    (dbg_occupancy)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] p, input logic lv, input logic le,
                         input logic rv, input logic rt);
        pc            = p;
        lookup_valid  = lv;
        lookup_enable = le;
        resolve_valid = rv;
        resolve_taken = rt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic check_state(input string tag, input logic full, input logic ovf,
                               input int unsigned rc, input int unsigned mc,
                               input logic [7:0] ghr, input int occ);
        check({tag, "_full"}, 32'(queue_full), 32'(full));
        check({tag, "_ovf"},  32'(overflow), 32'(ovf));
        check({tag, "_rc"},   resolved_count, rc);
        check({tag, "_mc"},   mispredict_count, mc);
        check({tag, "_ghr"},  32'(dbg_ghr), 32'(ghr));
        check({tag, "_occ"},  32'(dbg_occupancy), 32'(occ));
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned idx;
        bit          pred;
        int unsigned ghr;
    } ent_t;

    ent_t        exp_q[$];
    int unsigned m_pht[256];
    int unsigned m_ghr;
    int unsigned m_rc, m_mc;
    bit          m_ovf;

    function automatic void model_reset();
        foreach (m_pht[i]) m_pht[i] = 1;
        m_ghr = 0;
        m_rc  = 0;
        m_mc  = 0;
        m_ovf = 0;
        exp_q.delete();
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        lv, le, rv, rt;
        logic        pred, misp, full, ovf;
        logic [31:0] rc, mc;
        logic [7:0]  ghr;
        int          occ;
        logic [1:0]  pht20;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int unsigned idx, e_pht;
        bit          e_pred, e_misp, lf, rf;
        logic [31:0] p;
        logic        lv, le, rv, rt;
        ent_t        e;

        // pc, lv, le, rv, rt | pred, misp, full, ovf, rc, mc, ghr, occ, pht[0x20]
        vecs[0]  = '{32'h0000_0000, 0,0,0,0, 0,0,0,0, 0,0, 8'h00, 0, 2'b01};
        vecs[1]  = '{32'hFFFF_FFFE, 0,0,0,0, 0,0,0,0, 0,0, 8'h00, 0, 2'b01};
        vecs[2]  = '{32'h0000_0040, 1,1,0,0, 0,0,0,0, 0,0, 8'h00, 0, 2'b01};
        vecs[3]  = '{32'h0000_0040, 0,0,1,1, 0,1,0,0, 0,0, 8'h00, 1, 2'b01};
        vecs[4]  = '{32'h0000_0042, 0,0,0,0, 1,0,0,0, 1,1, 8'h01, 0, 2'b10};
        vecs[5]  = '{32'h0000_0042, 0,0,1,1, 1,0,0,0, 1,1, 8'h01, 0, 2'b10};
        vecs[6]  = '{32'h0000_0042, 0,0,0,0, 1,0,0,0, 1,1, 8'h01, 0, 2'b10};
        vecs[7]  = '{32'h0000_0042, 1,0,0,0, 1,0,0,0, 1,1, 8'h01, 0, 2'b10};
        vecs[8]  = '{32'h0000_0042, 0,0,0,0, 1,0,0,0, 1,1, 8'h01, 0, 2'b10};
        vecs[9]  = '{32'h0000_0042, 1,1,0,0, 1,0,0,0, 1,1, 8'h01, 0, 2'b10};
        vecs[10] = '{32'h0000_0042, 0,0,1,1, 0,0,0,0, 1,1, 8'h03, 1, 2'b10};
        vecs[11] = '{32'h0000_0042, 0,0,0,0, 0,0,0,0, 2,1, 8'h03, 0, 2'b11};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pc, vecs[i].lv, vecs[i].le, vecs[i].rv, vecs[i].rt);
            @(negedge clk);
            check($sformatf("vec%0d_pred", i), 32'(prediction), 32'(vecs[i].pred));
            check($sformatf("vec%0d_misp", i), 32'(mispredict), 32'(vecs[i].misp));
            check_state($sformatf("vec%0d", i), vecs[i].full, vecs[i].ovf,
                        vecs[i].rc, vecs[i].mc, vecs[i].ghr, vecs[i].occ);
            check($sformatf("vec%0d_pht20", i), 32'(dut.pht_q[8'h20]), 32'(vecs[i].pht20));
            next_cycle();
        end

        // ---- five not-taken resolves saturate the counter at 0 ----
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("nt%0d_pred", k), 32'(prediction), 32'd0);
            next_cycle();
            drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("nt%0d_misp", k), 32'(mispredict), 32'd0);
            next_cycle();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("nt_end", 1'b0, 1'b0, 5, 0, 8'h00, 0);
        check("nt_end_pht20", 32'(dut.pht_q[8'h20]), 32'd0);
        next_cycle();

        // ---- fill, then overflow with no pop ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("fill", 1'b1, 1'b0, 0, 0, 8'h00, 4);
        next_cycle();
        drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("ovf", 1'b1, 1'b1, 0, 0, 8'h00, 4);
        next_cycle();
        @(negedge clk);
        check("ovf_sticky", 32'(overflow), 32'd1);
        next_cycle();

        // ---- full queue: push with a same-cycle correct pop ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        drive(32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("pushpop_misp", 32'(mispredict), 32'd0);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("pushpop", 1'b1, 1'b0, 1, 0, 8'h00, 4);
        next_cycle();

        // ---- mispredict in the same cycle as a lookup ----
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        drive(32'h80, 1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("flush_misp", 32'(mispredict), 32'd1);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_state("flush", 1'b0, 1'b0, 1, 1, 8'h01, 0);
        check("flush_empty_misp", 32'(mispredict), 32'd0);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("flush_idle", 1'b0, 1'b0, 1, 1, 8'h01, 0);
        next_cycle();

        // ---- asynchronous reset with entries in flight ----
        do_reset();
        drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(32'h40, 1'b0, 1'b0, 1'b1, 1'b1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("pre_rst", 1'b0, 1'b0, 1, 1, 8'h08, 3);
        next_cycle();
        reset_n = 1'b0;
        #2;
        check_state("mid_rst", 1'b0, 1'b0, 0, 0, 8'h00, 0);
        check("mid_rst_pht20", 32'(dut.pht_q[8'h20]), 32'd1);
        check("mid_rst_pred", 32'(prediction), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        next_cycle();
        drive(32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("post_rst_pred", 32'(prediction), 32'd0);
        check("post_rst_occ", 32'(dbg_occupancy), 32'd0);
        next_cycle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state("post_rst", 1'b0, 1'b0, 0, 0, 8'h00, 1);
        next_cycle();

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
                model_reset();
            end
            p  = ($urandom & 32'hFFFF_FE00) | (32'($urandom_range(0, 31)) << 1) | 32'($urandom_range(0, 1));
            lv = ($urandom_range(0, 9) < 7);
            le = ($urandom_range(0, 9) < 8);
            rv = ($urandom_range(0, 9) < 4);
            rt = ($urandom_range(0, 3) != 0);
            drive(p, lv, le, rv, rt);
            @(negedge clk);

            idx    = ((p >> 1) & 32'hFF) ^ m_ghr;
            e_pred = (m_pht[idx] >= 2);
            lf     = lv && le;
            rf     = rv && (exp_q.size() > 0);
            e_misp = rf && (rt != exp_q[0].pred);

            check("rnd_pred", 32'(prediction), 32'(e_pred));
            check("rnd_misp", 32'(mispredict), 32'(e_misp));
            check_state("rnd", exp_q.size() == QD, m_ovf, m_rc, m_mc, 8'(m_ghr), exp_q.size());

            if (rf) begin
                e = exp_q.pop_front();
                e_pht = m_pht[e.idx];
                m_pht[e.idx] = rt ? ((e_pht == 3) ? 3 : e_pht + 1)
                                  : ((e_pht == 0) ? 0 : e_pht - 1);
                m_rc++;
                if (e_misp) begin
                    m_mc++;
                    m_ghr = ((e.ghr << 1) | 32'(rt)) & 32'hFF;
                    exp_q.delete();
                end else if (lf) begin
                    exp_q.push_back('{idx, e_pred, m_ghr});
                    m_ghr = ((m_ghr << 1) | 32'(e_pred)) & 32'hFF;
                end
            end else if (lf) begin
                if (exp_q.size() < QD) begin
                    exp_q.push_back('{idx, e_pred, m_ghr});
                    m_ghr = ((m_ghr << 1) | 32'(e_pred)) & 32'hFF;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            next_cycle();
        end

        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("rnd_pht%0d", i), 32'(dut.pht_q[i]), m_pht[i]);
        end

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter PHT_BITS, default 8, giving log2 of the number of pattern history table (PHT) entries.
REQ-002 The block SHALL have parameter GHR_BITS, default 8 (must be <= PHT_BITS), giving the global history register (GHR) width.
REQ-003 The block SHALL have parameter QDEPTH, default 4, giving the in-flight branch queue depth.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 pc  input  32  fetch PC being looked up.
REQ-007 lookup_valid  input  1  current fetch instruction is a conditional branch.
REQ-008 lookup_enable  input  1  fetch not stalled; lookup_fire = lookup_valid & lookup_enable.
REQ-009 prediction  output  1  combinational taken prediction for pc.
REQ-010 resolve_valid  input  1  oldest in-flight branch resolved this cycle.
REQ-011 resolve_taken  input  1  actual outcome of the resolved branch.
REQ-012 mispredict  output  1  combinational; resolve_fire & (resolve_taken != stored prediction).
REQ-013 queue_full  output  1  queue holds QDEPTH entries.
REQ-014 overflow  output  1  sticky error, lookup_fire while full without a same-cycle pop.
REQ-015 resolved_count  output  32  resolved branches, wraps at 2^32.
REQ-016 mispredict_count  output  32  mispredictions, wraps at 2^32.

Function
REQ-017 PHT SHALL be 2^PHT_BITS 2-bit saturating counters; prediction = PHT[idx][1].
REQ-018 idx SHALL be pc[PHT_BITS:1] XOR zero-extended GHR (pc[1] included for compressed instructions).
REQ-019 PHT read SHALL be combinational with no bypass; a same-cycle update to the same index is not visible until the next cycle.
REQ-020 On lookup_fire with no mispredict this cycle, the block SHALL enqueue {idx, prediction, GHR before shift} and set GHR <= {GHR[GHR_BITS-2:0], prediction}.
REQ-021 resolve_fire = resolve_valid & queue not empty; resolve_valid on an empty queue SHALL be ignored (no update, no count, mispredict=0).
REQ-022 On resolve_fire the block SHALL pop the oldest entry and update PHT[stored idx]: +1 saturating at 3 if taken, -1 saturating at 0 if not taken.
REQ-023 On resolve_fire the block SHALL increment resolved_count by 1, and mispredict_count by 1 when mispredict=1.
REQ-024 On mispredict, GHR SHALL become {stored GHR[GHR_BITS-2:0], resolve_taken}, and the queue SHALL be emptied, including any same-cycle lookup (wrong path).
REQ-025 Correctly predicted resolves SHALL leave GHR unchanged.
REQ-026 For simultaneous resolve_fire (correct) and lookup_fire on a full queue, pop SHALL precede push; no overflow; occupancy unchanged.
REQ-027 For lookup_fire while full without a pop, the block SHALL NOT enqueue, SHALL NOT shift GHR, and SHALL set overflow=1 until reset.
REQ-028 The queue SHALL be a circular FIFO with wrapping read/write pointers and an occupancy count 0..QDEPTH.

Reset
REQ-029 On reset_n low, asynchronously: every PHT counter 2'b01, GHR 0, queue empty, overflow 0, both counts 0; hence prediction=0, queue_full=0, mispredict=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries; the first cycle after release behaves as post-reset.

Verification
REQ-031 Reset -> prediction=0 for pc=0x0 and 0xFFFFFFFE; queue_full=0, overflow=0, counts 0.
REQ-032 With defaults, lookup pc=0x40 (idx 0x20, pred 0), then resolve taken -> mispredict=1, PHT[0x20]=2'b10, GHR=0x01, queue empty, mispredict_count=1.
REQ-033 Five lookups (pred 0) resolved not-taken on idx 0x20 from 2'b01 -> counter stays 2'b00, mispredict_count unchanged, resolved_count=5.
REQ-034 Four lookups without resolve -> queue_full=1; fifth lookup -> overflow=1, occupancy 4; fifth lookup plus same-cycle correct resolve -> overflow stays 0.
REQ-035 Mispredicting resolve in the same cycle as lookup_fire -> queue empty next cycle, GHR = restored value, no entry for the lookup.
REQ-036 Reset pulse with 3 entries queued -> occupancy 0, GHR 0, counters 2'b01, counts 0.
